// File: rtl/cpu_lsu_pkg.sv
// Shared types for the load/store unit: access-size encoding and LSU FSM
// states plus lane/misalignment helpers.
package pck_control;
    typedef enum logic [1:0] {
        be_byte = 2'd0,
        be_half = 2'd1,
        be_word = 2'd2
    } sel_be_e;
endpackage

package pck_lsu;
    import pck_control::*;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        RESP  = 2'd3
    } lsu_state_e;

    // Bits [3:0] are the lanes of the first word, bits [7:4] those of the next.
    function automatic logic [7:0] lane_mask(sel_be_e size, logic [1:0] off);
        logic [7:0] m;
        case (size)
            be_byte: m = 8'h01;
            be_half: m = 8'h03;
            default: m = 8'h0F;
        endcase
        return m << off;
    endfunction

    function automatic logic misaligned(sel_be_e size, logic [1:0] off);
        logic mis;
        case (size)
            be_half: mis = (off == 2'd3);
            be_word: mis = (off != 2'd0);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction
endpackage

// File: rtl/cpu_lsu_rd_format.sv
// Load result formatting: rotate merged lanes down, optional byte swap, extend.
module lsu_rd_format
    import pck_control::*;
(
    input  logic [31:0] data_i,
    input  logic [1:0]  off_i,
    input  sel_be_e     size_i,
    input  logic        sext_i,
    input  logic        swap_i,
    output logic [31:0] result_o
);
    logic [31:0] rot;
    logic [15:0] half;

    always_comb begin
        rot  = 32'({data_i, data_i} >> {off_i, 3'b000});
        half = swap_i ? {rot[7:0], rot[15:8]} : rot[15:0];
        case (size_i)
            be_byte: result_o = {{24{sext_i & rot[7]}}, rot[7:0]};
            be_half: result_o = {{16{sext_i & half[15]}}, half};
            default: result_o = swap_i ? {rot[7:0], rot[15:8], rot[23:16], rot[31:24]} : rot;
        endcase
    end
endmodule

// File: rtl/cpu_lsu.sv
// Load/store unit between execute and the data bus; splits misaligned accesses
// into two aligned beats. Optional ack-wait timeout via CPU_LSU_TIMEOUT_EN.
module cpu_lsu
    import pck_control::*;
    import pck_lsu::*;
#(
    parameter bit p_split_en   = 1'b1,
    parameter bit p_hold_rdata = 1'b1,
    parameter int p_timeout    = 255
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_wr,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    input  sel_be_e     i_req_be,
    input  logic        i_req_sext,
    input  logic        i_req_swap,
    output logic [31:0] dbus_addr,
    output logic [3:0]  dbus_be,
    output logic        dbus_wr_en,
    output logic [31:0] dbus_wr_data,
    output logic        dbus_rd_en,
    input  logic [31:0] dbus_rd_data,
    input  logic        dbus_busy,
    input  logic        dbus_ack,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err,
    output logic        o_busy
);
    lsu_state_e  state_q;
    logic        alive_q, wr_q, sext_q, swap_q, mis_q, err_q;
    logic [31:0] addr_q, wdata_q, merge_q, merge_d, last_q;
    sel_be_e     be_q;

    logic        accept, in_beat, strobe, ack_fire, timeout;
    logic [7:0]  mask;
    logic [3:0]  beat_mask;
    logic [31:0] base, fmt, rsp_data;
    logic [63:0] wshift;

    assign accept    = i_req_valid && o_req_ready;
    assign in_beat   = (state_q == BEAT0) || (state_q == BEAT1);
    // An ack is honoured even while busy is high, so the strobe follows it.
    assign strobe    = in_beat && (!dbus_busy || dbus_ack);
    assign ack_fire  = in_beat && dbus_ack;
    assign mask      = lane_mask(be_q, addr_q[1:0]);
    assign beat_mask = (state_q == BEAT1) ? mask[7:4] : mask[3:0];
    assign base      = {addr_q[31:2], 2'b00};
    assign wshift    = {32'b0, wdata_q} << {addr_q[1:0], 3'b000};

    assign dbus_addr    = (state_q == BEAT0) ? base :
                          (state_q == BEAT1) ? base + 32'd4 : 32'd0;
    assign dbus_be      = strobe ? beat_mask : 4'b0000;
    assign dbus_wr_en   = strobe && wr_q;
    assign dbus_rd_en   = strobe && !wr_q;
    assign dbus_wr_data = (in_beat && wr_q) ?
                          ((state_q == BEAT1) ? wshift[63:32] : wshift[31:0]) : 32'd0;

    always_comb begin
        merge_d = merge_q;
        for (int i = 0; i < 4; i++) begin
            if (beat_mask[i]) merge_d[8*i +: 8] = dbus_rd_data[8*i +: 8];
        end
    end

    lsu_rd_format u_fmt (
        .data_i  (merge_q),
        .off_i   (addr_q[1:0]),
        .size_i  (be_q),
        .sext_i  (sext_q),
        .swap_i  (swap_q),
        .result_o(fmt)
    );

    assign rsp_data    = (wr_q || err_q) ? 32'd0 : fmt;
    assign o_req_ready = (state_q == IDLE) && alive_q;
    assign o_busy      = (state_q != IDLE);
    assign o_rsp_valid = (state_q == RESP);
    assign o_rsp_err   = (state_q == RESP) && err_q;
    assign o_rsp_rdata = (state_q == RESP) ? rsp_data : (p_hold_rdata ? last_q : 32'd0);

`ifdef CPU_LSU_TIMEOUT_EN
    localparam int TW_RAW = $clog2(p_timeout + 1);
    localparam int TW     = (TW_RAW < 8) ? 8 : ((TW_RAW > 16) ? 16 : TW_RAW);
    logic [TW-1:0] wait_q;

    assign timeout = strobe && !dbus_ack && (wait_q == TW'(p_timeout - 1));

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wait_q <= '0;
        end else if (accept || ack_fire) begin
            wait_q <= '0;
        end else if (strobe && !dbus_ack) begin
            wait_q <= wait_q + TW'(1);
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^p_timeout;
    assign timeout        = 1'b0;
`endif

    // alive_q keeps ready low until the first clock after reset release.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= IDLE;
            alive_q <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= be_byte;
            sext_q  <= 1'b0;
            swap_q  <= 1'b0;
            mis_q   <= 1'b0;
            err_q   <= 1'b0;
            merge_q <= '0;
            last_q  <= '0;
        end else begin
            alive_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        wr_q    <= i_req_wr;
                        addr_q  <= i_req_addr;
                        wdata_q <= i_req_wdata;
                        be_q    <= i_req_be;
                        sext_q  <= i_req_sext;
                        swap_q  <= i_req_swap;
                        mis_q   <= misaligned(i_req_be, i_req_addr[1:0]);
                        merge_q <= '0;
                        err_q   <= misaligned(i_req_be, i_req_addr[1:0]) && !p_split_en;
                        state_q <= (misaligned(i_req_be, i_req_addr[1:0]) && !p_split_en) ?
                                   RESP : BEAT0;
                    end
                end
                BEAT0, BEAT1: begin
                    if (ack_fire) begin
                        merge_q <= merge_d;
                        state_q <= (state_q == BEAT0 && mis_q) ? BEAT1 : RESP;
                    end else if (timeout) begin
                        err_q   <= 1'b1;
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    last_q  <= rsp_data;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_lsu.sv
// Self-checking bench for cpu_lsu: directed table, misalignment error path,
// reset/ack corner sequences and randomized accesses against a byte-level model.
module tb_cpu_lsu;
    import pck_control::*;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_valid, ns_valid, req_wr, req_sext, req_swap;
    logic [31:0] req_addr, req_wdata;
    sel_be_e     req_be;
    logic [31:0] dbus_rd_data;
    logic        dbus_busy, dbus_ack;

    logic        req_ready, dbus_wr_en, dbus_rd_en, rsp_valid, rsp_err, busy;
    logic [31:0] dbus_addr, dbus_wr_data, rsp_rdata;
    logic [3:0]  dbus_be;

    logic        ns_req_ready, ns_wr_en, ns_rd_en, ns_rsp_valid, ns_rsp_err, ns_busy;
    logic [31:0] ns_addr, ns_wr_data, ns_rsp_rdata;
    logic [3:0]  ns_be;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q[$];
    logic [31:0] exp_be_q[$];
    logic [31:0] exp_wd_q[$];

    always #5 clk = ~clk;

    cpu_lsu #(.p_split_en(1'b1), .p_hold_rdata(1'b1), .p_timeout(TO)) u_dut (
        .i_clk(clk), .i_rstn(rstn), .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_wr(req_wr), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
        .i_req_be(req_be), .i_req_sext(req_sext), .i_req_swap(req_swap),
        .dbus_addr(dbus_addr), .dbus_be(dbus_be), .dbus_wr_en(dbus_wr_en),
        .dbus_wr_data(dbus_wr_data), .dbus_rd_en(dbus_rd_en), .dbus_rd_data(dbus_rd_data),
        .dbus_busy(dbus_busy), .dbus_ack(dbus_ack), .o_rsp_valid(rsp_valid),
        .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err), .o_busy(busy)
    );

    cpu_lsu #(.p_split_en(1'b0), .p_hold_rdata(1'b0), .p_timeout(TO)) u_dut_ns (
        .i_clk(clk), .i_rstn(rstn), .i_req_valid(ns_valid), .o_req_ready(ns_req_ready),
        .i_req_wr(req_wr), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
        .i_req_be(req_be), .i_req_sext(req_sext), .i_req_swap(req_swap),
        .dbus_addr(ns_addr), .dbus_be(ns_be), .dbus_wr_en(ns_wr_en),
        .dbus_wr_data(ns_wr_data), .dbus_rd_en(ns_rd_en), .dbus_rd_data(32'd0),
        .dbus_busy(1'b0), .dbus_ack(1'b0), .o_rsp_valid(ns_rsp_valid),
        .o_rsp_rdata(ns_rsp_rdata), .o_rsp_err(ns_rsp_err), .o_busy(ns_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] w);
        case (w)
            32'h0000_0200: return 32'h8001_1234;
            32'h0000_0300: return 32'h4433_2211;
            32'h0000_0304: return 32'h8877_6655;
            default:       return (w * 32'h9E37_79B1) ^ 32'hA5C3_0F1E;
        endcase
    endfunction

    function automatic logic [7:0] mem_byte(input logic [31:0] b);
        logic [31:0] w;
        w = mem_word({b[31:2], 2'b00});
        return w[8*b[1:0] +: 8];
    endfunction

    function automatic logic [31:0] lane_bits(input logic [31:0] be);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[8*i +: 8] = be[i] ? 8'hFF : 8'h00;
        return m;
    endfunction

    // Byte-by-byte view: every byte of the access lands in some word/lane;
    // consecutive bytes in the same word form one bus beat.
    task automatic model(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input sel_be_e size, input bit sext, input bit swap,
                         output logic [31:0] rdata);
        int n;
        logic [31:0] b, w, val, r;
        logic [1:0] lane;
        exp_q.delete(); exp_be_q.delete(); exp_wd_q.delete();
        n = (size == be_byte) ? 1 : (size == be_half) ? 2 : 4;
        val = 0;
        for (int k = 0; k < n; k++) begin
            b    = addr + k;
            w    = {b[31:2], 2'b00};
            lane = b[1:0];
            if (exp_q.size() == 0 || exp_q[exp_q.size()-1] != w) begin
                exp_q.push_back(w);
                exp_be_q.push_back(32'd0);
                exp_wd_q.push_back(32'd0);
            end
            exp_be_q[exp_be_q.size()-1] = exp_be_q[exp_be_q.size()-1] | (32'd1 << lane);
            exp_wd_q[exp_wd_q.size()-1] = exp_wd_q[exp_wd_q.size()-1] |
                                          (32'((wdata >> (8*k)) & 32'hFF) << (8*lane));
            val[8*k +: 8] = mem_byte(b);
        end
        r = val;
        if (swap) for (int k = 0; k < n; k++) r[8*k +: 8] = val[8*(n-1-k) +: 8];
        if (n == 1 && sext && r[7])  r[31:8]  = 24'hFFFFFF;
        if (n == 2 && sext && r[15]) r[31:16] = 16'hFFFF;
        rdata = wr ? 32'd0 : r;
    endtask

    // Drives one request, plays the bus slave (nb_fix busy cycles per beat,
    // or random when negative) and checks every beat and the response.
    task automatic run_access(input string tag, input bit wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input sel_be_e size, input bit sext,
                              input bit swap, input int nb_fix, input logic [31:0] exp_rdata,
                              input int exp_beats);
        int cyc = 0, bcnt = 0, nb, beats = 0, busy_total = 0;
        bit done = 0;
        nb = (nb_fix >= 0) ? nb_fix : $urandom_range(0, 2);
        @(negedge clk);
        req_wr = wr; req_addr = addr; req_wdata = wdata; req_be = size;
        req_sext = sext; req_swap = swap; req_valid = 1'b1;
        dbus_busy = 1'b0; dbus_ack = 1'b0;
        #1 check({tag, " ready"}, {31'b0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        while (!done && cyc < 100) begin
            cyc++;
            dbus_busy    = (bcnt < nb);
            dbus_ack     = !dbus_busy;
            dbus_rd_data = mem_word(dbus_addr);
            #1;
            if (rsp_valid) begin
                done = 1;
                check({tag, " rdata"}, rsp_rdata, exp_rdata);
                check({tag, " err"}, {31'b0, rsp_err}, 32'd0);
                check({tag, " beats"}, beats, exp_beats);
                check({tag, " latency"}, cyc, exp_beats + busy_total + 1);
            end else if (dbus_busy) begin
                busy_total++;
                bcnt++;
                check({tag, " busy strobe"}, {30'b0, dbus_rd_en, dbus_wr_en}, 32'd0);
                check({tag, " busy be"}, {28'b0, dbus_be}, 32'd0);
                if (exp_q.size() > 0) check({tag, " busy addr"}, dbus_addr, exp_q[0]);
            end else if (dbus_rd_en || dbus_wr_en) begin
                beats++;
                if (exp_q.size() == 0) begin
                    check({tag, " extra beat"}, beats, exp_beats);
                end else begin
                    check({tag, " addr"}, dbus_addr, exp_q.pop_front());
                    check({tag, " be"}, {28'b0, dbus_be}, exp_be_q[0]);
                    check({tag, " wr_en"}, {31'b0, dbus_wr_en}, {31'b0, wr});
                    if (wr) check({tag, " wdata"}, dbus_wr_data & lane_bits(exp_be_q[0]),
                                  exp_wd_q[0]);
                    void'(exp_be_q.pop_front());
                    void'(exp_wd_q.pop_front());
                end
                bcnt = 0;
                nb = (nb_fix >= 0) ? nb_fix : $urandom_range(0, 2);
            end else begin
                check({tag, " strobe"}, {31'b0, dbus_rd_en | dbus_wr_en}, 32'd1);
            end
            @(negedge clk);
        end
        dbus_busy = 1'b0; dbus_ack = 1'b0;
        if (!done) begin
            total++; bad++;
            $display("FAIL %s no response: got none expected rsp_valid", tag);
        end else begin
            #1;
            check({tag, " rsp single"}, {31'b0, rsp_valid}, 32'd0);
            check({tag, " rdata hold"}, rsp_rdata, exp_rdata);
            check({tag, " idle ready"}, {31'b0, req_ready}, 32'd1);
        end
    endtask

    task automatic ns_misaligned(input string tag, input bit wr, input logic [31:0] addr,
                                 input logic [31:0] wdata, input sel_be_e size);
        @(negedge clk);
        req_wr = wr; req_addr = addr; req_wdata = wdata; req_be = size;
        req_sext = 1'b0; req_swap = 1'b0; ns_valid = 1'b1;
        #1 check({tag, " ready"}, {31'b0, ns_req_ready}, 32'd1);
        @(negedge clk);
        ns_valid = 1'b0;
        #1;
        check({tag, " rsp_valid"}, {31'b0, ns_rsp_valid}, 32'd1);
        check({tag, " err"}, {31'b0, ns_rsp_err}, 32'd1);
        check({tag, " rdata"}, ns_rsp_rdata, 32'd0);
        check({tag, " no strobe"}, {26'b0, ns_be, ns_rd_en, ns_wr_en}, 32'd0);
        @(negedge clk);
        #1;
        check({tag, " after"}, {30'b0, ns_rsp_valid, ns_busy}, 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        check({tag, " ctl"}, {25'b0, req_ready, dbus_wr_en, dbus_rd_en, rsp_valid, rsp_err,
                              busy, ns_req_ready}, 32'd0);
        check({tag, " addr"}, dbus_addr, 32'd0);
        check({tag, " be"}, {28'b0, dbus_be}, 32'd0);
        check({tag, " wdata"}, dbus_wr_data, 32'd0);
        check({tag, " rdata"}, rsp_rdata, 32'd0);
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        sel_be_e     size;
        bit          sext;
        bit          swap;
        int          nb;
        logic [31:0] exp_rdata;
        int          exp_beats;
    } vec_t;

    vec_t tbl[12];

    initial begin
        logic [31:0] m_rdata, a;
        bit          r_wr;
        sel_be_e     r_size;
        int          n_strobe;

        tbl[0]  = '{1'b1, 32'h0000_0100, 32'hDEAD_BEEF, be_word, 1'b0, 1'b0, 0, 32'h0000_0000, 1};
        tbl[1]  = '{1'b0, 32'h0000_0202, 32'h0,         be_half, 1'b1, 1'b0, 0, 32'hFFFF_8001, 1};
        tbl[2]  = '{1'b0, 32'h0000_0202, 32'h0,         be_half, 1'b1, 1'b1, 0, 32'h0000_0180, 1};
        tbl[3]  = '{1'b0, 32'h0000_0301, 32'h0,         be_word, 1'b0, 1'b0, 0, 32'h5544_3322, 2};
        tbl[4]  = '{1'b1, 32'h0000_03FF, 32'h0000_ABCD, be_half, 1'b0, 1'b0, 0, 32'h0000_0000, 2};
        tbl[5]  = '{1'b0, 32'h0000_0300, 32'h0,         be_word, 1'b0, 1'b0, 3, 32'h4433_2211, 1};
        tbl[6]  = '{1'b0, 32'h0000_0303, 32'h0,         be_byte, 1'b0, 1'b0, 0, 32'h0000_0044, 1};
        tbl[7]  = '{1'b0, 32'h0000_0307, 32'h0,         be_byte, 1'b1, 1'b0, 1, 32'hFFFF_FF88, 1};
        tbl[8]  = '{1'b0, 32'h0000_0305, 32'h0,         be_half, 1'b0, 1'b1, 0, 32'h0000_6677, 1};
        tbl[9]  = '{1'b0, 32'h0000_0302, 32'h0,         be_word, 1'b0, 1'b1, 2, 32'h3344_5566, 2};
        tbl[10] = '{1'b1, 32'hFFFF_FFFE, 32'h0102_0304, be_word, 1'b0, 1'b0, 1, 32'h0000_0000, 2};
        tbl[11] = '{1'b0, 32'h0000_0306, 32'h0,         be_half, 1'b1, 1'b0, 0, 32'hFFFF_8877, 1};

        rstn = 1'b0; req_valid = 1'b0; ns_valid = 1'b0; req_wr = 1'b0;
        req_addr = '0; req_wdata = '0; req_be = be_byte; req_sext = 1'b0; req_swap = 1'b0;
        dbus_rd_data = '0; dbus_busy = 1'b0; dbus_ack = 1'b0;
        repeat (3) @(negedge clk);
        #1 chk_all_zero("reset");
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        #1 check("ready after reset", {31'b0, req_ready}, 32'd1);

        // A stray ack with no access in flight must change nothing.
        dbus_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1 check("stray ack", {29'b0, busy, rsp_valid, req_ready}, 32'd1);
        end
        dbus_ack = 1'b0;

        for (int i = 0; i < 12; i++) begin
            model(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].size, tbl[i].sext,
                  tbl[i].swap, m_rdata);
            run_access($sformatf("vec%0d", i), tbl[i].wr, tbl[i].addr, tbl[i].wdata,
                       tbl[i].size, tbl[i].sext, tbl[i].swap, tbl[i].nb,
                       tbl[i].exp_rdata, tbl[i].exp_beats);
        end

        ns_misaligned("ns ld word 301", 1'b0, 32'h0000_0301, 32'h0, be_word);
        ns_misaligned("ns st half 3ff", 1'b1, 32'h0000_03FF, 32'h0000_ABCD, be_half);

        for (int i = 0; i < 80; i++) begin
            r_wr   = 1'($urandom_range(0, 1));
            r_size = sel_be_e'($urandom_range(0, 2));
            a = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'h0000_FFF0);
            a = a | 32'($urandom_range(0, 15));
            req_sext = 1'($urandom_range(0, 1));
            req_swap = 1'($urandom_range(0, 1));
            req_wdata = $urandom;
            model(r_wr, a, req_wdata, r_size, req_sext, req_swap, m_rdata);
            run_access($sformatf("rnd%0d", i), r_wr, a, req_wdata, r_size, req_sext,
                       req_swap, -1, m_rdata, exp_q.size());
        end

`ifdef CPU_LSU_TIMEOUT_EN
        @(negedge clk);
        req_wr = 1'b0; req_addr = 32'h0000_0100; req_be = be_word;
        req_sext = 1'b0; req_swap = 1'b0; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0; dbus_busy = 1'b0; dbus_ack = 1'b0;
        n_strobe = 0;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (rsp_valid) break;
            if (dbus_rd_en) n_strobe++;
            @(negedge clk);
        end
        check("timeout strobes", n_strobe, TO);
        check("timeout rsp", {30'b0, rsp_valid, rsp_err}, 32'd3);
        check("timeout rdata", rsp_rdata, 32'd0);
`else
        n_strobe = 0;
`endif

        // Reset while the second beat of a split store is on the bus.
        @(negedge clk);
        req_wr = 1'b1; req_addr = 32'h0000_0301; req_wdata = 32'h1122_3344; req_be = be_word;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0; dbus_busy = 1'b0; dbus_ack = 1'b1;
        #1 check("rst seq beat0", {dbus_addr[31:1], dbus_wr_en}, {31'h0000_0180, 1'b1});
        @(negedge clk);
        dbus_ack = 1'b0;
        #1 check("rst seq beat1", {dbus_addr[31:1], dbus_wr_en}, {31'h0000_0182, 1'b1});
        #2 rstn = 1'b0;
        #1 chk_all_zero("mid reset");
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        #1 check("ready after mid reset", {29'b0, req_ready, busy, dbus_wr_en}, 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cpu_lsu.md
Name: cpu_lsu

Overview:
Parametrised load/store unit; successor to the single-beat data-memory stage, sitting between the execute stage and the data bus.
- Accepts one load/store per valid/ready handshake.
- Drives the data bus through a registered FSM.
- Splits misaligned word and half accesses into two aligned beats and merges read data.
- Returns a sign/zero-extended, optionally byte-swapped result with an error flag.

Parameters:
p_split_en, 1, 1: misaligned accesses are split into two beats; 0: misaligned accesses complete with error and no bus access
p_hold_rdata, 1, 1: o_rsp_rdata holds its last value until the next response; 0: o_rsp_rdata is 0 outside o_rsp_valid
p_timeout, 255, ack wait limit in cycles (used only with CPU_LSU_TIMEOUT_EN)

Ports:
i_clk  in  1  global clock, rising edge
i_rstn  in  1  asynchronous active-low reset
i_req_valid  in  1  request valid
o_req_ready  out  1  unit idle, request can be accepted
i_req_wr  in  1  1 = store, 0 = load
i_req_addr  in  32  byte address
i_req_wdata  in  32  store data (LSB-aligned)
i_req_be  in  sel_be_e  access size: be_byte, be_half or be_word
i_req_sext  in  1  sign-extend load result
i_req_swap  in  1  byte-swap load result (big to little endian)
dbus_addr  out  32  word-aligned bus address
dbus_be  out  4  write byte enable
dbus_wr_en  out  1  write strobe
dbus_wr_data  out  32  lane-aligned write data
dbus_rd_en  out  1  read strobe
dbus_rd_data  in  32  read data
dbus_busy  in  1  bus cannot accept a request
dbus_ack  in  1  beat complete
o_rsp_valid  out  1  single-cycle response pulse
o_rsp_rdata  out  32  load result (0 for stores)
o_rsp_err  out  1  misaligned access with p_split_en = 0, or timeout
o_busy  out  1  FSM not in IDLE

Behaviour:
- FSM states: IDLE, BEAT0, BEAT1, RESP.
- Reset (asynchronous, i_rstn low): every output is 0 and the FSM returns to IDLE.
  - A reset mid-operation abandons the access; a first beat already written is not undone.
- o_req_ready = (state == IDLE). Request fields are latched on i_req_valid && o_req_ready.
- Misalignment:
  - word access with addr[1:0] != 0 is misaligned;
  - half access with addr[1:0] == 3 is misaligned;
  - byte access is never misaligned.
- Misaligned access with p_split_en = 0: IDLE -> RESP directly, o_rsp_err = 1, no dbus strobe.
- Accept: IDLE -> BEAT0.
- BEAT0:
  - Drives addr & ~3 and the upper-lane be, e.g. word at offset 1 gives be 4'b1110.
  - dbus_wr_data = wdata shifted left by 8*offset.
  - The strobe (rd or wr) is asserted while dbus_busy is low and held until dbus_ack. While busy is high, the strobe is 0 and the address is held.
- BEAT0 on ack:
  - misaligned -> BEAT1;
  - otherwise -> RESP.
  - Read lanes are captured into a 32-bit merge buffer.
- BEAT1:
  - Drives (addr & ~3) + 4 (wraps modulo 2^32) and the remaining low lanes, e.g. word at offset 1 gives be 4'b0001.
  - Write data = wdata shifted right by 8*(4 - offset).
  - On ack: merge read bytes -> RESP.
- RESP:
  - o_rsp_valid = 1 for exactly one cycle, then -> IDLE.
  - Read path: rotate right by 8*offset, then extend:
    - byte: sext/zext of bits [7:0];
    - half: sext/zext of bits [15:0], with the halves byte-reversed first when swap = 1;
    - word: full 32 bits, all four bytes reversed when swap = 1.
- Timing:
  - Minimum latency for an aligned access with zero-wait ack: accept cycle 0, strobe cycle 1, ack cycle 1, o_rsp_valid cycle 2.
  - A split access adds one cycle per beat.
- dbus_ack while no strobe is asserted is ignored.
- dbus_ack and dbus_busy high together in the same cycle: ack takes priority.
- dbus_be is 0 whenever no strobe is asserted.

Optional Feature:
CPU_LSU_TIMEOUT_EN
- Defined:
  - An 8..16-bit wait counter (sized from p_timeout) clears at each beat start and counts cycles with a strobe asserted and no ack.
  - On reaching p_timeout, the strobe drops, the FSM goes -> RESP with o_rsp_err = 1, and o_rsp_rdata = 0.
- Undefined: no counter; the FSM waits for ack indefinitely.

Decomposition:
- Package pck_lsu holds:
  - the lsu_state_e enum (IDLE, BEAT0, BEAT1, RESP);
  - a function returning the lane mask for a (size, offset) pair;
  - a function returning the misaligned flag.
- sel_be_e is reused from pck_control.
- One combinational sub-module, lsu_rd_format, performs rotate, swap and extend; it takes (merged data, offset, size, sext, swap).

Test Plan:
- Aligned store word 0xDEADBEEF to 0x100, zero-wait ack -> one beat: addr 0x100, be 4'b1111, wr_data 0xDEADBEEF; rsp_valid 2 cycles after accept, err 0.
- Load half sext from 0x202 with bus word 0x8001_1234 -> one beat, rdata 0xFFFF8001; repeat with swap = 1 -> 0x00000180.
- Misaligned load word from 0x301, beat 0x300 returns 0x44332211 and beat 0x304 returns 0x88776655 -> two beats with be 1110/0001, rdata 0x55443322.
- Misaligned store half 0xABCD to 0x3FF with p_split_en = 0 -> no strobe, rsp_valid with err 1; with p_split_en = 1 -> beats 0x3FC be 1000 data 0xCD000000, then 0x400 be 0001 data 0x000000AB.
- dbus_busy high 3 cycles, then ack -> strobe low and address stable during busy; then a single strobe until ack.
- With CPU_LSU_TIMEOUT_EN and p_timeout = 4, ack never arrives -> strobe drops after 4 wait cycles, rsp_valid with err 1; separately, i_rstn pulsed low during BEAT1 -> all outputs 0 immediately, ready 1 after release.
